if_id_skid_stage: RTL and testbench

- Parametrised IF/ID pipeline boundary with a valid/ready handshake and a 2-entry skid buffer (main + skid).
- Carries {p4, pc, instr} from fetch to decode at full throughput.
- Absorbs one beat of downstream stall without combinational ready paths.
- Flush drops all held beats; the decode side sees a configurable NOP whenever it is not valid.

---
 rtl/pipe_pkg.sv | 12 +
 rtl/pipe_beat_reg.sv | 20 ++
 rtl/if_id_skid_stage.sv | 129 ++++++++++++
 tb/tb_if_id_skid_stage.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and occupancy encoding for the IF/ID skid stage.
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h00007013;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/pipe_beat_reg.sv
// Enable/clear register for one {p4, pc, instr} beat; clear value doubles as reset value.
module pipe_beat_reg #(
  parameter int unsigned W = 96
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] clr_val,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= clr_val;
    else if (clr) q <= clr_val;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline boundary: valid/ready handshake with a main + skid register pair.
module if_id_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     ILEN      = 32,
  parameter logic [ILEN-1:0] NOP_INSTR = ILEN'(NOP_INSTR_DEFAULT)
) (
  input  logic            i_clk,
  input  logic            i_resetn,
  input  logic            i_flush,
  input  logic            i_if_valid,
  output logic            o_if_ready,
  input  logic [XLEN-1:0] i_if_p4,
  input  logic [XLEN-1:0] i_if_pc,
  input  logic [ILEN-1:0] i_if_instr,
  output logic            o_id_valid,
  input  logic            i_id_ready,
  output logic [XLEN-1:0] o_id_p4,
  output logic [XLEN-1:0] o_id_pc,
  output logic [ILEN-1:0] o_id_instr,
  output logic [1:0]      o_occupancy
);

  localparam int unsigned BW = 2 * XLEN + ILEN;

  occ_e          state_q, state_d;
  logic          ready_q, valid_q;
  logic          accept, consume;
  logic          main_en, main_clr, main_from_skid, skid_en, skid_clr;
  logic [BW-1:0] in_beat, main_d, main_q, skid_q;
  logic [BW-1:0] main_clr_val, skid_clr_val;

  assign accept       = i_if_valid & ready_q;
  assign consume      = valid_q & i_id_ready;
  assign in_beat      = {i_if_p4, i_if_pc, i_if_instr};
  assign main_d       = main_from_skid ? skid_q : in_beat;
  assign main_clr_val = {XLEN'(0), XLEN'(0), NOP_INSTR};
  assign skid_clr_val = BW'(0);

  // State register plus registered ready/valid derived from the next state.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != TWO);
      valid_q <= (state_d != EMPTY);
    end
  end

  // Next-state and register-control decode; flush overrides everything.
  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_en        = 1'b0;
    skid_clr       = 1'b0;
    if (i_flush) begin
      state_d  = EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_en = 1'b1;
            state_d = ONE;
          end
        end
        ONE: begin
          if (consume && accept) begin
            main_en = 1'b1;
          end else if (consume) begin
            // Drop to NOP so an invalid output never shows stale data.
            main_clr = 1'b1;
            state_d  = EMPTY;
          end else if (accept) begin
            skid_en = 1'b1;
            state_d = TWO;
          end
        end
        TWO: begin
          if (consume) begin
            main_en        = 1'b1;
            main_from_skid = 1'b1;
            state_d        = ONE;
          end
        end
        default: begin
          state_d  = EMPTY;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  pipe_beat_reg #(.W(BW)) u_main (
    .clk     (i_clk),
    .rst_n   (i_resetn),
    .en      (main_en),
    .clr     (main_clr),
    .clr_val (main_clr_val),
    .d       (main_d),
    .q       (main_q)
  );

  pipe_beat_reg #(.W(BW)) u_skid (
    .clk     (i_clk),
    .rst_n   (i_resetn),
    .en      (skid_en),
    .clr     (skid_clr),
    .clr_val (skid_clr_val),
    .d       (in_beat),
    .q       (skid_q)
  );

  assign o_if_ready  = ready_q;
  assign o_id_valid  = valid_q;
  assign o_occupancy = state_q;
  assign o_id_p4     = main_q[BW-1 -: XLEN];
  assign o_id_pc     = main_q[ILEN+XLEN-1 -: XLEN];
  assign o_id_instr  = main_q[ILEN-1:0];

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Scenario bench for if_id_skid_stage with a FIFO scoreboard on the decode side.
module tb_if_id_skid_stage;

  localparam logic [31:0] NOP32 = 32'h00007013;
  localparam logic [31:0] NOP64 = 32'h00000013;

  typedef struct packed {
    logic [31:0] p4;
    logic [31:0] pc;
    logic [31:0] instr;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        if_valid = 1'b0;
  logic        if_ready;
  logic [31:0] if_p4 = '0, if_pc = '0, if_instr = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_p4, id_pc, id_instr;
  logic [1:0]  occ;

  logic        w_valid = 1'b0, w_ready_in = 1'b0;
  logic        w_if_ready, w_id_valid;
  logic [63:0] w_p4 = '0, w_pc = '0, w_id_p4, w_id_pc;
  logic [31:0] w_instr = '0, w_id_instr;
  logic [1:0]  w_occ;

  int    n_checks = 0;
  int    n_fail = 0;
  beat_t sb[$];

  always #5 clk = ~clk;

  if_id_skid_stage dut (
    .i_clk(clk), .i_resetn(rst_n), .i_flush(flush),
    .i_if_valid(if_valid), .o_if_ready(if_ready),
    .i_if_p4(if_p4), .i_if_pc(if_pc), .i_if_instr(if_instr),
    .o_id_valid(id_valid), .i_id_ready(id_ready),
    .o_id_p4(id_p4), .o_id_pc(id_pc), .o_id_instr(id_instr),
    .o_occupancy(occ)
  );

  if_id_skid_stage #(.XLEN(64), .ILEN(32), .NOP_INSTR(NOP64)) dut64 (
    .i_clk(clk), .i_resetn(rst_n), .i_flush(1'b0),
    .i_if_valid(w_valid), .o_if_ready(w_if_ready),
    .i_if_p4(w_p4), .i_if_pc(w_pc), .i_if_instr(w_instr),
    .o_id_valid(w_id_valid), .i_id_ready(w_ready_in),
    .o_id_p4(w_id_p4), .o_id_pc(w_id_pc), .o_id_instr(w_id_instr),
    .o_occupancy(w_occ)
  );

  function automatic logic [31:0] mk_instr(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0033;
  endfunction

  // Scoreboard: pop on consume, drop everything on flush, push on accept.
  always @(posedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (id_valid && id_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_underflow: consumed pc=%h but no beat expected", id_pc);
        end else begin
          beat_t e;
          e = sb.pop_front();
          if ({id_p4, id_pc, id_instr} !== e) begin
            n_fail++;
            $display("FAIL sb_order: got p4=%h pc=%h instr=%h want p4=%h pc=%h instr=%h",
                     id_p4, id_pc, id_instr, e.p4, e.pc, e.instr);
          end
        end
      end
      if (flush) sb.delete();
      else if (if_valid && if_ready) sb.push_back('{if_p4, if_pc, if_instr});
    end
  end

  // Invalid outputs must always present a harmless NOP.
  always @(negedge clk) begin
    if (rst_n && !id_valid) begin
      n_checks++;
      if (id_instr !== NOP32 || id_pc !== 32'h0 || id_p4 !== 32'h0) begin
        n_fail++;
        $display("FAIL idle_nop: instr=%h pc=%h p4=%h want %h/0/0", id_instr, id_pc, id_p4, NOP32);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] pc);
    if_valid = v;
    if_pc    = pc;
    if_p4    = pc + 32'd4;
    if_instr = mk_instr(pc);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if (id_valid !== 1'b0 || if_ready !== 1'b1 || occ !== 2'd0 || id_instr !== NOP32 ||
        id_pc !== 32'h0 || id_p4 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_vals: v=%b rdy=%b occ=%0d instr=%h pc=%h p4=%h", id_valid, if_ready,
               occ, id_instr, id_pc, id_p4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_stream();
    logic [31:0] pcs[3];
    pcs = '{32'h100, 32'h104, 32'h108};
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(1'b1, pcs[i]);
      step();
      n_checks++;
      if (id_valid !== 1'b1 || id_pc !== pcs[i] || occ !== 2'd1 || if_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_%0d: v=%b pc=%h occ=%0d rdy=%b want 1/%h/1/1", i, id_valid,
                 id_pc, occ, if_ready, pcs[i]);
      end
    end
    offer(1'b0, 32'h0);
    step();
    n_checks++;
    if (occ !== 2'd0 || id_valid !== 1'b0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL stream_drain: occ=%0d v=%b pending=%0d want 0/0/0", occ, id_valid, sb.size());
    end
  endtask

  task automatic test_stall();
    id_ready = 1'b0;
    offer(1'b1, 32'h200);
    step();
    offer(1'b1, 32'h204);
    step();
    n_checks++;
    if (occ !== 2'd2 || if_ready !== 1'b0 || id_pc !== 32'h200) begin
      n_fail++;
      $display("FAIL stall_full: occ=%0d rdy=%b pc=%h want 2/0/200", occ, if_ready, id_pc);
    end
    offer(1'b1, 32'h2FC);
    step();
    n_checks++;
    if (occ !== 2'd2 || id_pc !== 32'h200 || id_instr !== mk_instr(32'h200)) begin
      n_fail++;
      $display("FAIL stall_hold: occ=%0d pc=%h instr=%h want 2/200", occ, id_pc, id_instr);
    end
    offer(1'b0, 32'h0);
    id_ready = 1'b1;
    step();
    n_checks++;
    if (occ !== 2'd1 || id_pc !== 32'h204 || if_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_drain1: occ=%0d pc=%h rdy=%b want 1/204/1", occ, id_pc, if_ready);
    end
    step();
    n_checks++;
    if (occ !== 2'd0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL stall_drain2: occ=%0d pending=%0d want 0/0", occ, sb.size());
    end
  endtask

  task automatic test_flush_full();
    id_ready = 1'b0;
    offer(1'b1, 32'h280);
    step();
    offer(1'b1, 32'h284);
    step();
    flush = 1'b1;
    offer(1'b1, 32'h300);
    step();
    flush = 1'b0;
    offer(1'b0, 32'h0);
    n_checks++;
    if (id_valid !== 1'b0 || id_instr !== NOP32 || id_pc !== 32'h0 || occ !== 2'd0 ||
        if_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_full: v=%b instr=%h pc=%h occ=%0d rdy=%b want 0/%h/0/0/1", id_valid,
               id_instr, id_pc, occ, if_ready, NOP32);
    end
    id_ready = 1'b1;
    repeat (3) step();
    n_checks++;
    if (id_valid !== 1'b0 || occ !== 2'd0) begin
      n_fail++;
      $display("FAIL flush_ghost: v=%b pc=%h occ=%0d want nothing held", id_valid, id_pc, occ);
    end
  endtask

  task automatic test_flush_consume();
    id_ready = 1'b0;
    offer(1'b1, 32'h400);
    step();
    flush = 1'b1;
    id_ready = 1'b1;
    offer(1'b1, 32'h404);
    step();
    flush = 1'b0;
    offer(1'b0, 32'h0);
    n_checks++;
    if (occ !== 2'd0 || id_valid !== 1'b0 || if_ready !== 1'b1 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL flush_consume: occ=%0d v=%b rdy=%b pending=%0d want 0/0/1/0", occ,
               id_valid, if_ready, sb.size());
    end
    repeat (2) step();
  endtask

  task automatic test_async_reset();
    id_ready = 1'b0;
    offer(1'b1, 32'h500);
    step();
    offer(1'b1, 32'h504);
    step();
    offer(1'b0, 32'h0);
    n_checks++;
    if (occ !== 2'd2) begin
      n_fail++;
      $display("FAIL areset_setup: occ=%0d want 2", occ);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (id_valid !== 1'b0 || if_ready !== 1'b1 || occ !== 2'd0 || id_instr !== NOP32 ||
        id_pc !== 32'h0 || id_p4 !== 32'h0) begin
      n_fail++;
      $display("FAIL areset_vals: v=%b rdy=%b occ=%0d instr=%h pc=%h", id_valid, if_ready, occ,
               id_instr, id_pc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    id_ready = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_param64();
    n_checks++;
    if (w_id_instr !== NOP64 || w_id_valid !== 1'b0 || w_id_pc !== 64'h0) begin
      n_fail++;
      $display("FAIL p64_idle: instr=%h v=%b pc=%h want %h/0/0", w_id_instr, w_id_valid,
               w_id_pc, NOP64);
    end
    w_ready_in = 1'b1;
    w_valid    = 1'b1;
    w_pc       = 64'hFFFF_FFFF_0000_0010;
    w_p4       = 64'hFFFF_FFFF_0000_0014;
    w_instr    = 32'h0010_0093;
    step();
    w_valid = 1'b0;
    n_checks++;
    if (w_id_valid !== 1'b1 || w_id_pc !== 64'hFFFF_FFFF_0000_0010 ||
        w_id_p4 !== 64'hFFFF_FFFF_0000_0014 || w_id_instr !== 32'h0010_0093) begin
      n_fail++;
      $display("FAIL p64_pass: v=%b pc=%h p4=%h instr=%h", w_id_valid, w_id_pc, w_id_p4,
               w_id_instr);
    end
    step();
    n_checks++;
    if (w_id_valid !== 1'b0 || w_id_instr !== NOP64 || w_occ !== 2'd0) begin
      n_fail++;
      $display("FAIL p64_drain: v=%b instr=%h occ=%0d want 0/%h/0", w_id_valid, w_id_instr,
               w_occ, NOP64);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush_full();
    test_flush_consume();
    test_async_reset();
    test_param64();
    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
